// File: rtl/pmem_adapter_pkg.sv
// Shared sizing, state encoding and payload types for the L2 physical-memory line adapter.
package pmem_adapter_pkg;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned LINE_W     = 256;
  localparam int unsigned BEAT_W     = 64;
  localparam int unsigned BEATS      = 4;
  localparam int unsigned OFFSET_W   = 5;
  localparam int unsigned BEAT_IDX_W = $clog2(BEATS);
  localparam int unsigned LINE_IDX_W = $clog2(LINE_W);
  localparam int unsigned BEAT_SH    = $clog2(BEAT_W);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2,
    DONE     = 2'd3
  } state_e;

  // Request copy captured on burst entry; the live request inputs are ignored afterwards.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] line;
  } line_req_t;

  // Lowest line bit covered by beat k (beat 0 = bits 63:0).
  function automatic logic [LINE_IDX_W-1:0] beat_lsb(input logic [BEAT_IDX_W-1:0] k);
    return {k, BEAT_SH'(0)};
  endfunction

endpackage

// File: rtl/pmem_adapter_watchdog.sv
// Burst stall watchdog for pmem_line_adapter; only compiled when
// PMEM_LINE_ADAPTER_WATCHDOG_EN is defined.
`ifdef PMEM_LINE_ADAPTER_WATCHDOG_EN
module pmem_adapter_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic active_i,
  input  logic beat_i,
  output logic timeout_c_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counts consecutive stalled burst cycles; any accepted beat or leaving the burst clears it.
  always_comb begin
    cnt_d = cnt_q;
    if (!active_i || beat_i) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_W'(TIMEOUT_CYCLES)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires on the stalled cycle whose increment reaches the limit; a beat that cycle wins.
  assign timeout_c_o = active_i && !beat_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule
`endif

// File: rtl/pmem_line_adapter.sv
// L2 physical-memory responder: one 256-bit line request <-> four 64-bit memory beats.
// Optional burst watchdog enabled by defining PMEM_LINE_ADAPTER_WATCHDOG_EN.
module pmem_line_adapter
  import pmem_adapter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  pmem_address_i,
  input  logic               pmem_read_i,
  input  logic               pmem_write_i,
  input  logic [LINE_W-1:0]  pmem_wdata_i,
  output logic [LINE_W-1:0]  pmem_rdata_o,
  output logic               pmem_resp_o,
  output logic               pmem_err_o,
  output logic [ADDR_W-1:0]  mem_address_o,
  output logic               mem_read_o,
  output logic               mem_write_o,
  output logic [BEAT_W-1:0]  mem_wdata_o,
  input  logic [BEAT_W-1:0]  mem_rdata_i,
  input  logic               mem_resp_i
);

  state_e                state_q, state_d;
  logic [BEAT_IDX_W-1:0] k_q, k_d;
  line_req_t             req_q, req_d;
  logic [LINE_W-1:0]     rdata_q, rdata_d;
  logic                  resp_q, resp_d;
  logic                  err_q, err_d;
  logic                  rd_q, rd_d;
  logic                  wr_q, wr_d;
  logic [BEAT_W-1:0]     wdata_q, wdata_d;
  logic [ADDR_W-1:0]     maddr_q, maddr_d;
  logic                  hold_off_q, hold_off_d;

  logic                  in_burst_c;
  logic                  beat_c;
  logic                  last_beat_c;
  logic                  accept_c;
  logic                  timeout_c;
  logic                  unused_ok_c;

  assign in_burst_c  = (state_q == RD_BURST) || (state_q == WR_BURST);
  assign beat_c      = in_burst_c && mem_resp_i;
  assign last_beat_c = beat_c && (k_q == BEAT_IDX_W'(BEATS - 1));
  // The first IDLE cycle after DONE ignores requests so a lingering request is not re-accepted.
  assign accept_c    = (state_q == IDLE) && !hold_off_q && (pmem_read_i || pmem_write_i);

`ifdef PMEM_LINE_ADAPTER_WATCHDOG_EN
  pmem_adapter_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk         (clk),
    .rst         (rst),
    .active_i    (in_burst_c),
    .beat_i      (beat_c),
    .timeout_c_o (timeout_c)
  );
`else
  assign timeout_c = 1'b0;
`endif

  // Line-offset address bits are dropped by design; the limit is only consumed by the watchdog.
  assign unused_ok_c = ^{pmem_address_i[OFFSET_W-1:0], 32'(TIMEOUT_CYCLES)};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: write wins over read; DONE always returns to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          state_d = pmem_write_i ? WR_BURST : RD_BURST;
        end
      end
      RD_BURST, WR_BURST: begin
        if (last_beat_c || timeout_c) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath updates and next values of the registered outputs.
  always_comb begin
    req_d   = req_q;
    k_d     = k_q;
    rdata_d = rdata_q;

    if (accept_c) begin
      req_d.addr = {pmem_address_i[ADDR_W-1:OFFSET_W], OFFSET_W'(0)};
      req_d.line = pmem_wdata_i;
      k_d        = '0;
    end else if (beat_c) begin
      k_d = k_q + BEAT_IDX_W'(1);
      if (state_q == RD_BURST) begin
        rdata_d[beat_lsb(k_q) +: BEAT_W] = mem_rdata_i;
      end
    end

    rd_d       = (state_d == RD_BURST);
    wr_d       = (state_d == WR_BURST);
    maddr_d    = (rd_d || wr_d) ? req_d.addr : '0;
    wdata_d    = wr_d ? req_d.line[beat_lsb(k_d) +: BEAT_W] : '0;
    resp_d     = (state_d == DONE);
    err_d      = timeout_c;
    hold_off_d = (state_q == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k_q        <= '0;
      req_q      <= '0;
      rdata_q    <= '0;
      resp_q     <= 1'b0;
      err_q      <= 1'b0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      wdata_q    <= '0;
      maddr_q    <= '0;
      hold_off_q <= 1'b0;
    end else begin
      k_q        <= k_d;
      req_q      <= req_d;
      rdata_q    <= rdata_d;
      resp_q     <= resp_d;
      err_q      <= err_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      wdata_q    <= wdata_d;
      maddr_q    <= maddr_d;
      hold_off_q <= hold_off_d;
    end
  end

  assign pmem_rdata_o  = rdata_q;
  assign pmem_resp_o   = resp_q;
  assign pmem_err_o    = err_q;
  assign mem_address_o = maddr_q;
  assign mem_read_o    = rd_q;
  assign mem_write_o   = wr_q;
  assign mem_wdata_o   = wdata_q;

endmodule

// File: doc/pmem_line_adapter.md
# pmem_line_adapter

Memory-side responder for the L2 cache's physical-memory port. Accepts one 256-bit cacheline read or write request from the L2 controller. Converts it into a 4-beat, 64-bit burst on the main-memory bus. Returns a single-cycle completion pulse. Sits between the L2 cache datapath/control and the main-memory model.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: idle-beat limit before a burst is aborted (used only with the watchdog feature).

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- pmem_address_i  in  32  line address from L2
- pmem_read_i  in  1  line read request, level, held until pmem_resp_o
- pmem_write_i  in  1  line write request, level, held until pmem_resp_o
- pmem_wdata_i  in  256  line to write; stable while pmem_write_i high
- pmem_rdata_o  out  256  assembled read line, registered
- pmem_resp_o  out  1  completion pulse, one cycle
- pmem_err_o  out  1  completion was a timeout abort
- mem_address_o  out  32  burst base address, {pmem_address_i[31:5], 5'b0}
- mem_read_o  out  1  burst read, held for the whole burst
- mem_write_o  out  1  burst write, held for the whole burst
- mem_wdata_o  out  64  current write beat
- mem_rdata_i  in  64  read beat, valid when mem_resp_i high
- mem_resp_i  in  1  per-beat acknowledge

## Operation
- States: IDLE, RD_BURST, WR_BURST, DONE.
- IDLE:
  - pmem_write_i high: go to WR_BURST.
  - Else pmem_read_i high: go to RD_BURST.
  - Write wins if both are high.
  - On entry to a burst: latch the address, the write line and the op; clear beat counter k (2 bits).
- RD_BURST:
  - mem_read_o=1.
  - On each cycle with mem_resp_i=1: store mem_rdata_i into pmem_rdata_o[64k+63:64k], then increment k.
  - When the beat with k=3 is accepted: go to DONE.
- WR_BURST:
  - mem_write_o=1; mem_wdata_o = latched line[64k+63:64k].
  - k increments on each mem_resp_i.
  - When the beat with k=3 is accepted: go to DONE.
- Beats are in ascending order, beat 0 = bits 63:0. Gaps between beats (mem_resp_i low) are allowed and simply stall.
- DONE:
  - pmem_resp_o=1 for exactly one cycle, then unconditionally go to IDLE.
  - The requester must drop its request in the cycle after pmem_resp_o.
  - IDLE always lasts at least one cycle, so the same request is never re-accepted.
- pmem_rdata_o holds the last completed (or partially filled, on abort) line until the next read overwrites it.
- Write bursts never modify pmem_rdata_o.
- mem_address_o is driven from the latched address during bursts and is 0 in IDLE/DONE.
- Request inputs that change mid-burst are ignored. Only the latched copies are used.

## Timing
- Reset values: state IDLE, k=0, pmem_rdata_o=0, pmem_resp_o=0, pmem_err_o=0, mem_read_o=0, mem_write_o=0, mem_wdata_o=0, mem_address_o=0.
- rst mid-burst: mem_read_o/mem_write_o low in the cycle after the reset edge. No pmem_resp_o is issued for the aborted request.
- mem_read_o/mem_write_o/mem_wdata_o/mem_address_o/pmem_resp_o are decoded from registered state only. No combinational path from any input.
- Minimum latency: request sampled at edge 0, burst active cycles 1–4 with back-to-back mem_resp_i, pmem_resp_o in cycle 5.
- pmem_rdata_o is final in the DONE cycle.
- mem_resp_i while in IDLE or DONE is ignored.

## Configuration
- PMEM_LINE_ADAPTER_WATCHDOG_EN defined:
  - A counter clears on burst entry and on every accepted beat, and increments otherwise.
  - When it reaches TIMEOUT_CYCLES: drop mem_read_o/mem_write_o, go to DONE, assert pmem_err_o together with pmem_resp_o for that one cycle.
  - A beat arriving in the same cycle as the timeout wins: the counter clears, no abort.
- Macro undefined: no counter, pmem_err_o tied 0, bursts wait indefinitely, TIMEOUT_CYCLES unused.

## Structure
- Package pmem_adapter_pkg:
  - localparams LINE_W=256, BEAT_W=64, BEATS=4, OFFSET_W=5.
  - State enum type.
- Sub-module pmem_adapter_watchdog: the timeout counter, instantiated only under PMEM_LINE_ADAPTER_WATCHDOG_EN.
- Datapath and FSM stay in the top module.

## Test plan
- Read, addr 0x0000_1234, beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 back-to-back → mem_address_o=0x0000_1220, pmem_resp_o in cycle 5, pmem_rdata_o = {0x44..,0x33..,0x22..,0x11..}.
- Write, line with word i = i (64-bit), mem_resp_i with 2-cycle gaps → mem_wdata_o sequence 0,1,2,3, each held until acked; pmem_resp_o once; pmem_rdata_o unchanged.
- pmem_read_i and pmem_write_i both high → mem_write_o asserted, mem_read_o never asserted.
- rst asserted after beat 1 of a read → mem_read_o low the next cycle, no pmem_resp_o; a fresh read then completes normally.
- Watchdog on, TIMEOUT_CYCLES=8, read with only 2 beats acked → abort 8 cycles after the last beat; pmem_resp_o=pmem_err_o=1 for one cycle; mem_read_o low.
- Requester holds pmem_read_i one cycle past pmem_resp_o → exactly one burst issued.
